// File: rtl/fifo_sync_prog_if.sv
`default_nettype none
// ============================================================================
// Module   : fifo_sync_prog_if
// Purpose  : Producer/consumer bundle for fifo_sync_prog (push, pop, status).
// Revision : 1.0 - initial release
// ============================================================================
interface fifo_sync_prog_if #(
    parameter int DATA_WIDTH = 8,
    parameter int ADDR_WIDTH = 4
);
    logic                  wr_en;
    logic [DATA_WIDTH-1:0] data_in;
    logic                  rd_en;
    logic                  clr_err;
    logic [DATA_WIDTH-1:0] data_out;
    logic                  data_valid;
    logic                  full;
    logic                  empty;
    logic                  almost_full;
    logic                  almost_empty;
    logic [ADDR_WIDTH:0]   fill_level;
    logic                  overflow;
    logic                  underflow;

    modport master (
        output wr_en, data_in, rd_en, clr_err,
        input  data_out, data_valid, full, empty, almost_full, almost_empty,
               fill_level, overflow, underflow
    );

    modport slave (
        input  wr_en, data_in, rd_en, clr_err,
        output data_out, data_valid, full, empty, almost_full, almost_empty,
               fill_level, overflow, underflow
    );
endinterface
`default_nettype wire

// File: rtl/fifo_sync_prog.sv
`default_nettype none
// ============================================================================
// Module   : fifo_sync_prog
// Purpose  : Single-clock FIFO with programmable almost flags, fill level,
//            sticky error flags; FIFO_FWFT_EN selects first-word-fall-through.
// Revision : 1.0 - initial release
// ============================================================================
module fifo_sync_prog #(
    parameter int DATA_WIDTH = 8,
    parameter int ADDR_WIDTH = 4,
    parameter int FIFO_DEPTH = (1 << ADDR_WIDTH),
    parameter int AF_THRESH  = FIFO_DEPTH - 2,
    parameter int AE_THRESH  = 2
) (
    input  wire logic       clk,
    input  wire logic       rst,
    fifo_sync_prog_if.slave bus
);
    localparam int              c_cnt_w = ADDR_WIDTH + 1;
    localparam logic [c_cnt_w-1:0] c_depth = c_cnt_w'(FIFO_DEPTH);
    localparam logic [c_cnt_w-1:0] c_af    = c_cnt_w'(AF_THRESH);
    localparam logic [c_cnt_w-1:0] c_ae    = c_cnt_w'(AE_THRESH);

    logic [DATA_WIDTH-1:0] r_mem [FIFO_DEPTH];
    logic [ADDR_WIDTH-1:0] r_wr_ptr;
    logic [ADDR_WIDTH-1:0] r_rd_ptr;
    logic [c_cnt_w-1:0]    r_count;
    logic                  r_overflow;
    logic                  r_underflow;

    logic w_full;
    logic w_empty;
    logic w_wr_acc;
    logic w_rd_acc;

    // Accept decisions use this cycle's registered count only, so a full FIFO
    // never writes through and an empty one never reads through.
    assign w_full   = (r_count == c_depth);
    assign w_empty  = (r_count == '0);
    assign w_wr_acc = bus.wr_en & ~w_full;
    assign w_rd_acc = bus.rd_en & ~w_empty;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_wr_ptr    <= '0;
            r_rd_ptr    <= '0;
            r_count     <= '0;
            r_overflow  <= 1'b0;
            r_underflow <= 1'b0;
        end else begin
            if (w_wr_acc) r_wr_ptr <= r_wr_ptr + ADDR_WIDTH'(1);
            if (w_rd_acc) r_rd_ptr <= r_rd_ptr + ADDR_WIDTH'(1);
            case ({w_wr_acc, w_rd_acc})
                2'b10:   r_count <= r_count + c_cnt_w'(1);
                2'b01:   r_count <= r_count - c_cnt_w'(1);
                default: r_count <= r_count;
            endcase
            // Setting wins over clearing when both happen in one cycle.
            if (bus.wr_en && w_full)  r_overflow  <= 1'b1;
            else if (bus.clr_err)     r_overflow  <= 1'b0;
            if (bus.rd_en && w_empty) r_underflow <= 1'b1;
            else if (bus.clr_err)     r_underflow <= 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (w_wr_acc) r_mem[r_wr_ptr] <= bus.data_in;
    end

`ifdef FIFO_FWFT_EN
    assign bus.data_out   = r_mem[r_rd_ptr];
    assign bus.data_valid = ~w_empty;
`else
    logic [DATA_WIDTH-1:0] r_data_out;
    logic                  r_data_valid;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_data_out   <= '0;
            r_data_valid <= 1'b0;
        end else begin
            r_data_valid <= w_rd_acc;
            if (w_rd_acc) r_data_out <= r_mem[r_rd_ptr];
        end
    end

    assign bus.data_out   = r_data_out;
    assign bus.data_valid = r_data_valid;
`endif

    assign bus.full         = w_full;
    assign bus.empty        = w_empty;
    assign bus.almost_full  = (r_count >= c_af);
    assign bus.almost_empty = (r_count <= c_ae);
    assign bus.fill_level   = r_count;
    assign bus.overflow     = r_overflow;
    assign bus.underflow    = r_underflow;
endmodule
`default_nettype wire
